loop_div: RTL and testbench

//  Iterative restoring divider (shift-subtract); inverse of the shift-add loop multiplier.

---
 rtl/loop_pkg.sv | 25 ++
 rtl/loop_div_if.sv | 41 ++++
 rtl/loop_div_step.sv | 33 +++
 rtl/loop_div.sv | 117 +++++++++++
 tb/tb_loop_div.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/loop_pkg.sv
// Shared definitions for the shift-and-iterate arithmetic units (divider and
// multiplier): FSM state encoding, default operand widths and a constant
// helper for sizing iteration counters.
package loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LOOP_N = 16;
  localparam int LOOP_M = 8;

  // Number of bits needed to hold values 0 .. v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/loop_div_if.sv
// Request/result bundle of the iterative divider.
// Optional feature macro: LOOP_DIV_ERR_EN adds the divide-by-zero flag err.
//
// Handshake: the master raises start with dividend/divisor; the divider
// accepts on the first posedge where it is IDLE or DONE (start is ignored
// while busy). Operands are sampled only on that accepting edge. ready
// then rises N edges later (1 edge for a flagged divide-by-zero) and
// quotient/remainder stay stable until the next accepted start or reset.
interface loop_div_if #(
  parameter int N = loop_pkg::LOOP_N,
  parameter int M = loop_pkg::LOOP_M
);

  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
`ifdef LOOP_DIV_ERR_EN
  logic         err;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef LOOP_DIV_ERR_EN
    input  err,
`endif
    input  busy, ready, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef LOOP_DIV_ERR_EN
    output err,
`endif
    output busy, ready, quotient, remainder
  );

endinterface

// File: rtl/loop_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, keep the difference and
// emit a 1 quotient bit when it does not go negative.
module loop_div_step #(
  parameter int N = loop_pkg::LOOP_N,
  parameter int M = loop_pkg::LOOP_M
) (
  input  logic [M:0]   rem,
  input  logic [N-1:0] q,
  input  logic [M-1:0] d,
  output logic [M:0]   rem_next,
  output logic [N-1:0] q_next
);

  logic [M:0] shifted;
  logic [M:0] trial;
  logic       fits;
  // The remainder MSB is shifted out; it is only ever set when the divisor
  // is zero, where the upper bits carry no meaning.
  logic       unused_rem_msb;

  assign unused_rem_msb = rem[M];

  // Shift, trial-subtract and select the restored or reduced remainder.
  always_comb begin
    shifted  = {rem[M-1:0], q[N-1]};
    trial    = shifted - {1'b0, d};
    fits     = (shifted >= {1'b0, d});
    rem_next = fits ? trial : shifted;
    q_next   = {q[N-2:0], fits};
  end

endmodule

// File: rtl/loop_div.sv
// Iterative restoring divider: N-bit unsigned dividend by M-bit unsigned
// divisor, one quotient bit per clock. Holds the FSM, iteration counter and
// operand/result registers; the datapath step lives in loop_div_step.
// Optional feature macro: LOOP_DIV_ERR_EN -- divide-by-zero finishes in one
// cycle and raises err instead of running the full iteration.
module loop_div
  import loop_pkg::*;
#(
  parameter int N = LOOP_N,
  parameter int M = LOOP_M
) (
  input  logic     clk,
  input  logic     reset,
  loop_div_if.slave bus,
  output state_t   dbg_state
);

  localparam int CW = clog2(N + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  q_r;
  logic [M:0]    rem_r;
  logic [M-1:0]  d_r;
  logic          busy_r;
  logic          ready_r;
  logic [M:0]    rem_nx;
  logic [N-1:0]  q_nx;
  logic          last_iter;
`ifdef LOOP_DIV_ERR_EN
  logic          err_r;
`endif

  loop_div_step #(.N(N), .M(M)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .d        (d_r),
    .rem_next (rem_nx),
    .q_next   (q_nx)
  );

  assign last_iter = (count == CW'(N - 1));

  // Control FSM plus operand/result registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      q_r     <= '0;
      rem_r   <= '0;
      d_r     <= '0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
`ifdef LOOP_DIV_ERR_EN
      err_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            q_r     <= bus.dividend;
            d_r     <= bus.divisor;
            rem_r   <= '0;
            count   <= '0;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
`ifdef LOOP_DIV_ERR_EN
            err_r   <= 1'b0;
`endif
            state   <= BUSY;
          end
        end
        BUSY: begin
`ifdef LOOP_DIV_ERR_EN
          if (d_r == '0) begin
            // Short-circuit: same values the full iteration would produce.
            q_r     <= '1;
            rem_r   <= {1'b0, q_r[M-1:0]};
            count   <= CW'(N);
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            err_r   <= 1'b1;
            state   <= DONE;
          end else begin
`endif
            q_r   <= q_nx;
            rem_r <= rem_nx;
            count <= count + 1'b1;
            if (last_iter) begin
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
              state   <= DONE;
            end
`ifdef LOOP_DIV_ERR_EN
          end
`endif
        end
        default: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Results are read straight from the working registers.
  assign bus.busy      = busy_r;
  assign bus.ready     = ready_r;
  assign bus.quotient  = q_r;
  assign bus.remainder = rem_r[M-1:0];
`ifdef LOOP_DIV_ERR_EN
  assign bus.err       = err_r;
`endif
  assign dbg_state     = state;

endmodule

// File: tb/tb_loop_div.sv
// Self-checking bench for loop_div: directed divisions with hand-computed
// results, protocol corner cases and a short run of random operand pairs.
module tb_loop_div;
  import loop_pkg::*;

  localparam int N  = 16;
  localparam int M  = 8;
  localparam int EW = 1 + N + M;
`ifdef LOOP_DIV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  loop_div_if #(.N(N), .M(M)) bus ();

  loop_div #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic          ready_q = 1'b0;
  int            lat;
  int            bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: on each rising ready, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (reset) begin
      ready_q = 1'b0;
    end else begin
      if (bus.ready && !ready_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h/%0h required=none",
                   bus.quotient, bus.remainder);
        end else begin
          exp_e = exp_q.pop_front();
          check("quotient", 32'(bus.quotient), 32'(exp_e[N+M-1:M]));
          check("remainder", 32'(bus.remainder), 32'(exp_e[M-1:0]));
          check("busy_at_ready", 32'(bus.busy), 32'd0);
`ifdef LOOP_DIV_ERR_EN
          check("err", 32'(bus.err), 32'(exp_e[EW-1]));
`endif
        end
      end
      ready_q = bus.ready;
    end
  end

  // Driver: present one request for a single accepting edge.
  task automatic issue(input logic [N-1:0] dvd, input logic [M-1:0] dvs, input bit push,
                       input logic [N-1:0] eq, input logic [M-1:0] er);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    if (push) exp_q.push_back({ERR_EN && (dvs == '0), eq, er});
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = M'($urandom);
  endtask

  // Bounded wait for ready; lat counts negedges after the accepting edge.
  task automatic wait_ready(input int max, output int l, output int b);
    l = -1;
    b = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        l = n;
        break;
      end
      if (bus.busy) b++;
    end
    if (l < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none required=ready within %0d cycles", max);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset, with start asserted to show reset wins.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
`ifdef LOOP_DIV_ERR_EN
    check("reset_err", 32'(bus.err), 32'd0);
`endif
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(dbg_state), 32'(IDLE));

    // 1000 / 7 with latency and busy-length checks.
    issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6);
    wait_ready(40, lat, bcnt);
    check("latency_1000_7", 32'(lat), 32'd16);
    check("busy_cycles_1000_7", 32'(bcnt), 32'd16);
    check("done_state", 32'(dbg_state), 32'(DONE));

    issue(16'd65535, 8'd255, 1'b1, 16'd257, 8'd0);
    wait_ready(40, lat, bcnt);
    issue(16'd5, 8'd9, 1'b1, 16'd0, 8'd5);
    wait_ready(40, lat, bcnt);

    // Divide by zero.
    issue(16'h1234, 8'd0, 1'b1, 16'hFFFF, 8'h34);
    wait_ready(40, lat, bcnt);
    check("latency_div0", 32'(lat), ERR_EN ? 32'd1 : 32'd16);

    // start during BUSY is ignored.
    issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_ignored_start", 32'(dbg_state), 32'(BUSY));
    wait_ready(40, lat, bcnt);
    check("latency_ignored_start", 32'(lat), 32'd10);

    // Reset mid-operation aborts.
    issue(16'd1000, 8'd7, 1'b0, 16'd0, 8'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    issue(16'd200, 8'd10, 1'b1, 16'd20, 8'd0);
    wait_ready(40, lat, bcnt);

    // Back-to-back restart from DONE.
    check("ready_before_restart", 32'(bus.ready), 32'd1);
    issue(16'd300, 8'd17, 1'b1, 16'd17, 8'd11);
    check("ready_drops_on_restart", 32'(bus.ready), 32'd0);
    check("busy_on_restart", 32'(bus.busy), 32'd1);
    wait_ready(40, lat, bcnt);

    // start held high: one result per pass.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd50000;
    bus.divisor  = 8'd200;
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 16'd250, 8'd0});
    for (int k = 0; k < 3; k++) begin
      wait_ready(40, lat, bcnt);
      if (k > 0) check("held_start_latency", 32'(lat), 32'd16);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("held_start_stops", 32'(bus.ready), 32'd1);

    // Random nonzero-divisor pairs against the arithmetic reference.
    for (int k = 0; k < 100; k++) begin
      logic [N-1:0] dvd;
      logic [M-1:0] dvs;
      dvd = N'($urandom_range(0, 65535));
      dvs = M'($urandom_range(1, 255));
      issue(dvd, dvs, 1'b1, dvd / N'(dvs), M'(dvd % N'(dvs)));
      wait_ready(40, lat, bcnt);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
